// File: rtl/piho_metro_sweep.sv
// Metropolis sweep engine for a periodic path-integral harmonic oscillator path held in BRAM.
// Each point takes a fixed MATH_LAT+8 cycles: three neighbour reads, wait, action unit, decide, write, next.
module piho_metro_sweep #(
  parameter int PATH_N      = 5,
  parameter int W           = 32,
  parameter int NCONF       = 130000,
  parameter int NDUMP       = 10000,
  parameter int NSKIP       = 600,
  parameter int ADDR_BASE   = 0,
  parameter int ADDR_STRIDE = 8,
  parameter int MATH_LAT    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         hot_start,
  input  logic [W-1:0] rand_inc,
  input  logic [W-1:0] rnglog,
  output logic [W-1:0] math_x,
  output logic [W-1:0] math_xm,
  output logic [W-1:0] math_xp,
  output logic [W-1:0] math_inc,
  output logic         math_start,
  input  logic [W-1:0] math_ds,
  output logic [31:0]  bram_addr,
  output logic [63:0]  bram_din,
  input  logic [63:0]  bram_dout,
  output logic         bram_en,
  output logic [7:0]   bram_we,
  output logic         busy,
  output logic         sample_valid,
  output logic [31:0]  sweep_cnt,
  output logic [31:0]  accept_cnt,
  output logic         done
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_INIT    = 4'd1;
  localparam logic [3:0] S_RD_M    = 4'd2;
  localparam logic [3:0] S_RD_0    = 4'd3;
  localparam logic [3:0] S_RD_P    = 4'd4;
  localparam logic [3:0] S_RD_WAIT = 4'd5;
  localparam logic [3:0] S_CALC    = 4'd6;
  localparam logic [3:0] S_DECIDE  = 4'd7;
  localparam logic [3:0] S_WRITE   = 4'd8;
  localparam logic [3:0] S_NEXT    = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;

  localparam logic [15:0] LAST_IDX = 16'(PATH_N - 1);
  localparam logic [15:0] LAT_END  = 16'(MATH_LAT);
  localparam logic [31:0] NCONF_W  = 32'(NCONF);
  localparam logic [31:0] NDUMP_W  = 32'(NDUMP);
  localparam logic [31:0] SKIP_END = 32'(NSKIP - 1);

  logic [3:0]   state;
  logic [15:0]  idx;
  logic [15:0]  calc_cnt;
  logic         hot;
  logic         acc;
  logic [W-1:0] x_r, xm_r, xp_r, inc_r, xnew;
  logic [31:0]  skip_cnt;

  logic [15:0]  idx_m, idx_p, slot;
  logic [W:0]   sum;
  logic         accept;
  logic [31:0]  sweep_next;

  if (W < 64) begin : g_unused_dout
    logic unused_dout;
    assign unused_dout = ^bram_dout[63:W];
  end

  assign math_x   = x_r;
  assign math_xm  = xm_r;
  assign math_xp  = xp_r;
  assign math_inc = inc_r;
  assign math_start = (state == S_CALC) && (calc_cnt == 16'd0);

  assign idx_m = (idx == 16'd0) ? LAST_IDX : idx - 16'd1;
  assign idx_p = (idx == LAST_IDX) ? 16'd0 : idx + 16'd1;

  // The sum needs one extra bit so that large positive dS with very negative ln(u) cannot wrap.
  assign sum    = {rnglog[W-1], rnglog} + {math_ds[W-1], math_ds};
  assign accept = ($signed(math_ds) <= 0) || sum[W];

  assign sweep_next = (sweep_cnt == 32'hFFFF_FFFF) ? sweep_cnt : sweep_cnt + 32'd1;

  always_comb begin
    bram_en  = 1'b0;
    bram_we  = 8'h00;
    bram_din = 64'd0;
    slot     = idx;
    case (state)
      S_INIT: begin
        bram_en  = 1'b1;
        bram_we  = 8'hFF;
        bram_din = hot ? 64'($signed(rand_inc)) : 64'd0;
      end
      S_RD_M: begin
        bram_en = 1'b1;
        slot    = idx_m;
      end
      S_RD_0: bram_en = 1'b1;
      S_RD_P: begin
        bram_en = 1'b1;
        slot    = idx_p;
      end
      S_WRITE: begin
        bram_en  = acc;
        bram_we  = acc ? 8'hFF : 8'h00;
        bram_din = 64'($signed(xnew));
      end
      default: ;
    endcase
  end

  assign bram_addr = bram_en ? (32'(ADDR_BASE) + 32'(ADDR_STRIDE) * (32'(slot) + 32'd1)) : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= 16'd0;
      calc_cnt     <= 16'd0;
      hot          <= 1'b0;
      acc          <= 1'b0;
      x_r          <= '0;
      xm_r         <= '0;
      xp_r         <= '0;
      inc_r        <= '0;
      xnew         <= '0;
      skip_cnt     <= 32'd0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sweep_cnt    <= 32'd0;
      accept_cnt   <= 32'd0;
      done         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_INIT;
            hot        <= hot_start;
            sweep_cnt  <= 32'd0;
            accept_cnt <= 32'd0;
            done       <= 1'b0;
            busy       <= 1'b1;
            idx        <= 16'd0;
            skip_cnt   <= 32'd0;
          end
        end
        S_INIT: begin
          if (idx == LAST_IDX) begin
            idx   <= 16'd0;
            state <= S_RD_M;
          end else begin
            idx <= idx + 16'd1;
          end
        end
        S_RD_M: state <= S_RD_0;
        // Read data lags its address by one cycle, so each capture is one state behind its read.
        S_RD_0: begin
          xm_r  <= bram_dout[W-1:0];
          state <= S_RD_P;
        end
        S_RD_P: begin
          x_r   <= bram_dout[W-1:0];
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          xp_r     <= bram_dout[W-1:0];
          inc_r    <= rand_inc;
          calc_cnt <= 16'd0;
          state    <= S_CALC;
        end
        S_CALC: begin
          if (calc_cnt == LAT_END) state <= S_DECIDE;
          else calc_cnt <= calc_cnt + 16'd1;
        end
        S_DECIDE: begin
          acc  <= accept;
          xnew <= x_r + inc_r;
          if (accept && accept_cnt != 32'hFFFF_FFFF) accept_cnt <= accept_cnt + 32'd1;
          state <= S_WRITE;
        end
        S_WRITE: state <= S_NEXT;
        S_NEXT: begin
          if (idx != LAST_IDX) begin
            idx   <= idx + 16'd1;
            state <= S_RD_M;
          end else begin
            sweep_cnt <= sweep_next;
            // skip_cnt tracks (k - NDUMP - 1) mod NSKIP without a divider.
            if (sweep_next > NDUMP_W) begin
              if (skip_cnt == SKIP_END) begin
                sample_valid <= 1'b1;
                skip_cnt     <= 32'd0;
              end else begin
                skip_cnt <= skip_cnt + 32'd1;
              end
            end
            idx   <= 16'd0;
            state <= (sweep_next == NCONF_W) ? S_DONE : S_RD_M;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
